alu_top: RTL and testbench

Board-level wrapper around an 8-bit ALU for switch-driven bring-up:
- Operand A, operand B and the opcode are loaded one at a time from a single 8-bit switch bus `sw`, each under its own load-enable.
- The ALU result and status flags are computed from the three internal registers and driven to LEDs.
- It sits directly under the FPGA top, between debounced switch/button inputs and the LED outputs.

---
 rtl/alu_top.sv | 179 +++++++++++++++++
 tb/tb_alu_top.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_top.sv
// -----------------------------------------------------------------------------
// alu_top
//
// Board-level wrapper around a W-bit ALU for switch-driven bring-up. Operand A,
// operand B and the opcode are loaded one at a time from the shared switch bus
// `sw`, each under its own load-enable. The result and status flags are
// computed from the three internal registers and driven to LEDs.
//
// Ports:
//   clk       in   1    system clock, rising edge
//   rst       in   1    synchronous, active-high reset (clears A, B, OP)
//   en_a      in   1    load sw into A
//   en_b      in   1    load sw into B
//   en_op     in   1    load sw[WOP-1:0] into OP
//   sw        in   W    shared switch data bus
//   y         out  W    ALU result
//   carry     out  1    ADD carry-out
//   borrow    out  1    SUB borrow (unsigned A < B)
//   overflow  out  1    signed overflow for ADD/SUB
//   zero      out  1    y == 0
//   neg       out  1    y[W-1]
//
// Configuration:
//   ALU_TOP_OUTREG_EN  when defined, y and all flags pass through one output
//                      register stage (reset value: y=0, zero=1, others 0).
//                      When undefined, outputs are combinational from A/B/OP.
// -----------------------------------------------------------------------------
module alu_top #(
  parameter int W   = 8,
  parameter int WOP = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_a,
  input  logic         en_b,
  input  logic         en_op,
  input  logic [W-1:0] sw,
  output logic [W-1:0] y,
  output logic         carry,
  output logic         borrow,
  output logic         overflow,
  output logic         zero,
  output logic         neg
);

  // Opcode encodings (6-bit function codes, sized to the opcode register).
  localparam logic [WOP-1:0] OP_ADD = WOP'(6'b100000);
  localparam logic [WOP-1:0] OP_SUB = WOP'(6'b100010);
  localparam logic [WOP-1:0] OP_AND = WOP'(6'b100100);
  localparam logic [WOP-1:0] OP_OR  = WOP'(6'b100101);
  localparam logic [WOP-1:0] OP_XOR = WOP'(6'b100110);
  localparam logic [WOP-1:0] OP_NOR = WOP'(6'b100111);
  localparam logic [WOP-1:0] OP_SRL = WOP'(6'b000010);
  localparam logic [WOP-1:0] OP_SRA = WOP'(6'b000011);

  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [WOP-1:0] op_q, op_d;

  // Operand/opcode load: each register captures sw under its own enable and
  // holds otherwise; simultaneous enables all load the same sw value.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    a_d  = a_q;
    b_d  = b_q;
    op_d = op_q;
    if (en_a)  a_d  = sw;
    if (en_b)  b_d  = sw;
    if (en_op) op_d = sw[WOP-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      op_q <= op_d;
    end
  end

  // ALU datapath.
  logic [W:0]   sum_w;
  logic [W-1:0] diff;
  logic [2:0]   shamt;
  logic [W-1:0] res_y;
  logic         res_carry, res_borrow, res_overflow, res_zero, res_neg;

  assign sum_w = {1'b0, a_q} + {1'b0, b_q};
  assign diff  = a_q - b_q;
  assign shamt = b_q[2:0];  // upper bits of B do not affect shifts

  always_comb begin
    res_y        = '0;
    res_carry    = 1'b0;
    res_borrow   = 1'b0;
    res_overflow = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_y        = sum_w[W-1:0];
        res_carry    = sum_w[W];
        // Same-sign operands producing a result of the other sign.
        res_overflow = (a_q[W-1] == b_q[W-1]) && (sum_w[W-1] != a_q[W-1]);
      end
      OP_SUB: begin
        res_y        = diff;
        res_borrow   = (a_q < b_q);
        // Opposite-sign operands where the result sign departs from A.
        res_overflow = (a_q[W-1] != b_q[W-1]) && (diff[W-1] != a_q[W-1]);
      end
      OP_AND:  res_y = a_q & b_q;
      OP_OR:   res_y = a_q | b_q;
      OP_XOR:  res_y = a_q ^ b_q;
      OP_NOR:  res_y = ~(a_q | b_q);
      OP_SRL:  res_y = a_q >> shamt;
      OP_SRA:  res_y = W'($signed(a_q) >>> shamt);
      default: res_y = '0;
    endcase
    res_zero = (res_y == '0);
    res_neg  = res_y[W-1];
  end

`ifdef ALU_TOP_OUTREG_EN
  logic [W-1:0] y_q, y_d;
  logic         carry_q, carry_d;
  logic         borrow_q, borrow_d;
  logic         overflow_q, overflow_d;
  logic         zero_q, zero_d;
  logic         neg_q, neg_d;

  always_comb begin
    y_d        = res_y;
    carry_d    = res_carry;
    borrow_d   = res_borrow;
    overflow_d = res_overflow;
    zero_d     = res_zero;
    neg_d      = res_neg;
  end

  // Reset value matches what the cleared A/B/OP registers would produce.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q        <= '0;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
      neg_q      <= 1'b0;
    end else begin
      y_q        <= y_d;
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
    end
  end

  assign y        = y_q;
  assign carry    = carry_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign neg      = neg_q;
`else
  assign y        = res_y;
  assign carry    = res_carry;
  assign borrow   = res_borrow;
  assign overflow = res_overflow;
  assign zero     = res_zero;
  assign neg      = res_neg;
`endif

endmodule

// File: tb/tb_alu_top.sv
// -----------------------------------------------------------------------------
// tb_alu_top
//
// Self-checking bench for alu_top: directed vectors with hand-computed results,
// reset/hold/simultaneous-enable cases, then 300 seeded random vectors checked
// against an independent reference model. Outputs are sampled on the falling
// edge, one full cycle after the last load edge.
// -----------------------------------------------------------------------------
module tb_alu_top;

  localparam int W = 8;

  localparam logic [7:0] ADD = 8'b00100000;
  localparam logic [7:0] SUB = 8'b00100010;
  localparam logic [7:0] AND = 8'b00100100;
  localparam logic [7:0] OR  = 8'b00100101;
  localparam logic [7:0] XOR = 8'b00100110;
  localparam logic [7:0] NOR = 8'b00100111;
  localparam logic [7:0] SRL = 8'b00000010;
  localparam logic [7:0] SRA = 8'b00000011;
  localparam logic [7:0] BAD = 8'b00111111;

  logic         clk = 1'b0;
  logic         rst;
  logic         en_a, en_b, en_op;
  logic [W-1:0] sw;
  logic [W-1:0] y;
  logic         carry, borrow, overflow, zero, neg;

  int checks = 0;
  int errors = 0;

  alu_top #(.W(W), .WOP(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .en_a     (en_a),
    .en_b     (en_b),
    .en_op    (en_op),
    .sw       (sw),
    .y        (y),
    .carry    (carry),
    .borrow   (borrow),
    .overflow (overflow),
    .zero     (zero),
    .neg      (neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one load cycle: enables set at a falling edge, captured on the
  // following rising edge, cleared at the next falling edge.
  task automatic drive(input bit ea, input bit eb, input bit eo, input logic [7:0] v);
    @(negedge clk);
    sw = v; en_a = ea; en_b = eb; en_op = eo;
    @(negedge clk);
    en_a = 1'b0; en_b = 1'b0; en_op = 1'b0;
  endtask

  // Load A, B, OP in sequence, then let one more edge pass before sampling.
  task automatic load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    drive(1, 0, 0, a);
    drive(0, 1, 0, b);
    drive(0, 0, 1, op);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [7:0] ey, input bit ec,
                           input bit eb, input bit eo, input bit ez, input bit en);
    check({tag, ".y"},        32'(y),        32'(ey));
    check({tag, ".carry"},    32'(carry),    32'(ec));
    check({tag, ".borrow"},   32'(borrow),   32'(eb));
    check({tag, ".overflow"}, 32'(overflow), 32'(eo));
    check({tag, ".zero"},     32'(zero),     32'(ez));
    check({tag, ".neg"},      32'(neg),      32'(en));
  endtask

  // Reference model, written from integer arithmetic; packs {y,c,b,o,z,n}.
  function automatic logic [12:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
    int ua, ub, sa, sb, r;
    logic [7:0] ry;
    logic c, bo, o;
    ua = int'(a); ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    ry = 8'h00; c = 0; bo = 0; o = 0;
    case (op)
      6'b100000: begin
        r = ua + ub; ry = r[7:0]; c = (r > 255);
        o = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      6'b100010: begin
        r = ua - ub; ry = r[7:0]; bo = (ua < ub);
        o = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      6'b100100: ry = a & b;
      6'b100101: ry = a | b;
      6'b100110: ry = a ^ b;
      6'b100111: ry = ~(a | b);
      6'b000010: begin r = ua / (1 << ub[2:0]); ry = r[7:0]; end
      6'b000011: begin
        r = sa;
        for (int k = 0; k < int'(ub[2:0]); k++) r = (r < 0) ? -((-r + 1) / 2) : r / 2;
        ry = r[7:0];
      end
      default: ry = 8'h00;
    endcase
    return {ry, c, bo, o, (ry == 8'h00), ry[7]};
  endfunction

  logic [7:0] ops [8] = '{ADD, SUB, AND, OR, XOR, NOR, SRL, SRA};

  initial begin
    logic [7:0] ra, rb, rop;
    rst = 1'b1; en_a = 0; en_b = 0; en_op = 0; sw = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all("reset", 8'h00, 0, 0, 0, 1, 0);

    load(8'h05, 8'h03, ADD);  check_all("add_5_3",    8'h08, 0, 0, 0, 0, 0);
    load(8'hFF, 8'h01, ADD);  check_all("add_ff_1",   8'h00, 1, 0, 0, 1, 0);
    load(8'h7F, 8'h01, ADD);  check_all("add_ovf",    8'h80, 0, 0, 1, 0, 1);
    load(8'h10, 8'h20, SUB);  check_all("sub_10_20",  8'hF0, 0, 1, 0, 0, 1);
    load(8'h80, 8'h01, SUB);  check_all("sub_80_1",   8'h7F, 0, 0, 1, 0, 0);
    load(8'h06, 8'h04, SRL);  check_all("srl_6_4",    8'h00, 0, 0, 0, 1, 0);
    load(8'h90, 8'h0A, SRL);  check_all("srl_90_a",   8'h24, 0, 0, 0, 0, 0);
    load(8'h90, 8'h0A, SRA);  check_all("sra_90_a",   8'hE4, 0, 0, 0, 0, 1);
    load(8'hF0, 8'h3C, AND);  check_all("and",        8'h30, 0, 0, 0, 0, 0);
    load(8'hF0, 8'h3C, OR);   check_all("or",         8'hFC, 0, 0, 0, 0, 1);
    load(8'hF0, 8'h3C, XOR);  check_all("xor",        8'hCC, 0, 0, 0, 0, 1);
    load(8'hF0, 8'h3C, NOR);  check_all("nor",        8'h03, 0, 0, 0, 0, 0);
    load(8'hFF, 8'hFF, BAD);  check_all("bad_op",     8'h00, 0, 0, 0, 1, 0);

    // Simultaneous A+B load under ADD, then hold with no enables.
    drive(0, 0, 1, ADD);
    drive(1, 1, 0, 8'h21);
    @(negedge clk);
    check_all("simul_ab", 8'h42, 0, 0, 0, 0, 0);
    sw = 8'h99;
    repeat (3) @(negedge clk);
    check_all("hold", 8'h42, 0, 0, 0, 0, 0);

    // Reset mid-sequence wins over an active enable and clears all registers.
    @(negedge clk);
    rst = 1'b1; en_a = 1'b1; sw = 8'h77;
    @(negedge clk);
    rst = 1'b0; en_a = 1'b0;
    @(negedge clk);
    check_all("mid_rst", 8'h00, 0, 0, 0, 1, 0);
    drive(0, 0, 1, ADD);
    drive(0, 1, 0, 8'h03);
    @(negedge clk);
    check_all("after_rst", 8'h03, 0, 0, 0, 0, 0);

    // Seeded random vectors against the reference model.
    void'($urandom(32'd20240611));
    for (int i = 0; i < 300; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rop = (i % 4 == 0) ? 8'($urandom_range(0, 63)) : ops[$urandom_range(0, 7)];
      load(ra, rb, rop);
      check($sformatf("rand%0d a=%02h b=%02h op=%02h", i, ra, rb, rop),
            32'({y, carry, borrow, overflow, zero, neg}), 32'(model(ra, rb, rop[5:0])));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
